spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
Shares one SPI master transfer engine (slave-select/transfer-control block plus shift register) among NREQ requesters, e.g. CPU APB path and DMA.
- Arbitrates requests round-robin.
- Latches the winner's TX byte and launches the transfer with a one-cycle send_data pulse.
- Tracks tip/receive_data to completion, then returns the received byte and a done pulse to the winner.
- A watchdog aborts transfers whose tip never asserts.

Parameters:
NREQ, 2, number of requesters (2..4)
TMO_W, 16, width of the watchdog counter
TMO_CYC, 16'd4096, PCLK cycles allowed in WAIT_TIP before abort

Ports:
PCLK  in  1  clock
PRESETn  in  1  async active-low reset
req  in  NREQ  per-requester transfer request, level
wdata  in  8*NREQ  TX bytes, requester i at [8i+7:8i]
gnt  out  NREQ  one-hot grant, held for the whole transfer
done  out  NREQ  one-cycle completion pulse to the granted requester
err  out  1  one-cycle pulse with done when the transfer was aborted
rdata  out  8  received byte, valid from the done cycle until the next done
busy  out  1  high in every state except IDLE
send_data  out  1  launch pulse to the transfer-control block
spi_tx  out  8  byte loaded into the shift register
tip  in  1  transfer in progress from the transfer-control block
receive_data  in  1  one-cycle end-of-byte strobe from the transfer-control block
spi_rx  in  8  shift-register receive byte, valid when receive_data=1

Behaviour:
Clock and reset: reset is PRESETn, asynchronous, active-low; the clock is PCLK.

Reset values:
- Outputs: gnt=0, done=0, err=0, rdata=8'h00, busy=0, send_data=0, spi_tx=8'h00.
- Internal: state=IDLE, rr_ptr=NREQ-1 (requester 0 wins first), watchdog=0.
- Reset mid-transfer abandons it silently; no done is issued.

States:
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr+1 upward, modulo NREQ.
  - Registered on the same edge: gnt=onehot(winner), spi_tx=wdata[winner], rr_ptr=winner.
  - Go to LAUNCH.
- LAUNCH:
  - send_data=1 for exactly this one cycle; clear the watchdog.
  - Go to WAIT_TIP.
- WAIT_TIP:
  - tip=1 → WAIT_RCV.
  - Otherwise increment the watchdog. When watchdog==TMO_CYC-1 → ABORT.
- WAIT_RCV:
  - On receive_data=1, capture spi_rx into rdata → DONE.
  - If tip falls without receive_data, still go to DONE, keep the old rdata, and set err.
- DONE:
  - done[winner]=1 for one cycle; err=1 in this cycle if the transfer was flagged.
  - gnt clears on the next edge → IDLE.
- ABORT:
  - done[winner]=1 and err=1 for one cycle; rdata is unchanged.
  - → IDLE.

Latency and timing:
- Minimum latency from req to the send_data pulse is 2 cycles (IDLE→LAUNCH, then the pulse).
- IDLE is always visited for at least 1 cycle between transfers, so back-to-back requests from the same requester are separated by ≥1 idle cycle.

Requester rules:
- A requester keeps req high until it sees its done.
- req falling while granted does not cancel the transfer; it completes and done is issued anyway.
- wdata is sampled only in the arbitration cycle; later changes are ignored.

Simultaneous events and boundaries:
- receive_data and tip falling in the same cycle count as a normal completion (no err).
- A req rising during a transfer waits; it is considered at the next IDLE.
- rr_ptr wraps from NREQ-1 to 0.
- gnt is always one-hot or zero; done is only ever asserted on the bit that is set in gnt.

Optional Feature:
Macro SPI_ARB_LOCK_EN adds input port lock (NREQ bits).
- With the macro: if lock[winner]=1 in DONE, go directly to LAUNCH instead of IDLE.
  - gnt stays asserted and spi_tx reloads from wdata[winner] in the DONE cycle.
  - This gives multi-byte bursts with no idle gap and no arbitration until lock drops.
  - rr_ptr is not updated during a locked burst.
- Without the macro: no lock port, and DONE always returns to IDLE.

Test Plan:
- Single requester: req=01, wdata0=8'hA5, model drives tip 3 cycles after send_data and receive_data 20 cycles later with spi_rx=8'h3C → exactly one send_data pulse, spi_tx=8'hA5, done=01, rdata=8'h3C, err=0, busy low afterwards.
- Contention: req=11 held continuously, each transfer completing → grants alternate 01,10,01,10; each done goes only to the current gnt bit.
- Watchdog: req=10, tip never asserts → done=10 and err=1 exactly TMO_CYC cycles after WAIT_TIP entry; rdata unchanged; next request serviced normally.
- Premature end: tip drops without receive_data → done with err=1, rdata retains the previous value.
- Reset mid-transfer: assert PRESETn=0 during WAIT_RCV → all outputs at reset values immediately, no done; after release req=10 is granted only after req 0 has priority check (rr_ptr=NREQ-1).
- With SPI_ARB_LOCK_EN: lock=01, three bytes 11/22/33 from requester 0 while req1 is high → three send_data pulses with no IDLE cycle between them, gnt stays 01 throughout; requester 1 is granted after lock drops.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI transfer engine among NREQ requesters; req to send_data is 2 cycles,
// losers wait with req held until their gnt/done. `SPI_ARB_LOCK_EN adds a lock port for back-to-back bursts.
module spi_xfer_arbiter #(
  parameter int               NREQ    = 2,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = 16'd4096
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   wdata,
`ifdef SPI_ARB_LOCK_EN
  input  logic [NREQ-1:0]     lock,
`endif
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic [7:0]          rdata,
  output logic                busy,
  output logic                send_data,
  output logic [7:0]          spi_tx,
  input  logic                tip,
  input  logic                receive_data,
  input  logic [7:0]          spi_rx
);

  localparam int               IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TMO_W-1:0] WD_LAST = TMO_CYC - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_TIP,
    S_WAIT_RCV,
    S_DONE,
    S_ABORT
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     win;
  logic [IW-1:0]     arb_idx;
  logic [IW-1:0]     cand;
  logic              arb_vld;
  logic [NREQ-1:0]   arb_oh;
  logic [TMO_W-1:0]  wd_cnt;
  logic              xfer_err;
  logic              lock_hit;
  logic [7:0]        wbyte [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_wbyte
    assign wbyte[g] = wdata[8*g +: 8];
  end

`ifdef SPI_ARB_LOCK_EN
  assign lock_hit = |(lock & gnt);
`else
  assign lock_hit = 1'b0;
`endif

  // Descending scan so the candidate closest to rr_ptr+1 is the last one written.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IW'((int'(rr_ptr) + i) % NREQ);
      if (req[cand]) begin
        arb_vld = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    arb_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_oh[i] = (arb_idx == IW'(i));
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    send_data = 1'b0;
    busy      = (state != S_IDLE);
    done      = '0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_vld) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        send_data = 1'b1;
        state_nxt = S_WAIT_TIP;
      end
      S_WAIT_TIP: begin
        if (tip)                    state_nxt = S_WAIT_RCV;
        else if (wd_cnt == WD_LAST) state_nxt = S_ABORT;
      end
      S_WAIT_RCV: begin
        if (receive_data || !tip) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = gnt;
        err       = xfer_err;
        state_nxt = lock_hit ? S_LAUNCH : S_IDLE;
      end
      S_ABORT: begin
        done      = gnt;
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gnt      <= '0;
      spi_tx   <= 8'h00;
      rdata    <= 8'h00;
      rr_ptr   <= IW'(NREQ - 1);
      win      <= '0;
      wd_cnt   <= '0;
      xfer_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_vld) begin
            gnt    <= arb_oh;
            spi_tx <= wbyte[arb_idx];
            rr_ptr <= arb_idx;
            win    <= arb_idx;
          end
        end
        S_LAUNCH: begin
          wd_cnt   <= '0;
          xfer_err <= 1'b0;
        end
        S_WAIT_TIP: begin
          if (!tip) wd_cnt <= wd_cnt + 1'b1;
        end
        S_WAIT_RCV: begin
          // A tip drop with no strobe keeps the previous byte and flags the transfer.
          if (receive_data) rdata    <= spi_rx;
          else if (!tip)    xfer_err <= 1'b1;
        end
        S_DONE: begin
          if (lock_hit) spi_tx <= wbyte[win];
          else          gnt    <= '0;
        end
        S_ABORT: begin
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: vector table, reset/lock sequences, and randomized transfers vs a round-robin model.
module tb_spi_xfer_arbiter;

  localparam int TMO = 32;
  localparam int M_NORM = 0, M_EARLY = 1, M_TMO = 2, M_SIM = 3;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] wdata = '0;
  logic        tip = 1'b0;
  logic        receive_data = 1'b0;
  logic [7:0]  spi_rx = '0;
  logic [1:0]  gnt, done;
  logic        err, busy, send_data;
  logic [7:0]  rdata, spi_tx;
`ifdef SPI_ARB_LOCK_EN
  logic [1:0]  lock = '0;
`endif

  always #5 PCLK = ~PCLK;

  spi_xfer_arbiter #(.NREQ(2), .TMO_W(16), .TMO_CYC(16'(TMO))) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .wdata(wdata),
`ifdef SPI_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .send_data(send_data), .spi_tx(spi_tx), .tip(tip),
    .receive_data(receive_data), .spi_rx(spi_rx)
  );

  typedef struct {
    logic [1:0] req;
    logic [7:0] wd0, wd1, rx;
    int         mode, tip_dly, rcv_dly;
    logic [1:0] e_gnt;
    logic [7:0] e_tx, e_rd;
    logic       e_err;
  } vec_t;

  typedef struct {
    bit         seen;
    int         n_send, stray, lat;
    logic [1:0] gnt_l, done, gnt_d, gnt_after;
    logic       err, busy_after;
    logic [7:0] tx, tx_d, rdata;
  } obs_t;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Drives the engine side (tip/receive_data) for one transfer and records what the arbiter did.
  task automatic run_xfer(input vec_t v, input bit keep, output obs_t o);
    int s, k;
    bit fin;
    o = '{default: '0};
    s = -1;
    fin = 1'b0;
    req = v.req;
    wdata = {v.wd1, v.wd0};
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge PCLK);
      if (!$onehot0(gnt)) o.stray++;
      if ((done & ~gnt) != 2'b00 || (err && done == 2'b00)) o.stray++;
      if (send_data) begin
        o.n_send++;
        if (s < 0) begin
          s = cyc;
          o.tx = spi_tx;
          o.gnt_l = gnt;
        end
      end
      receive_data = 1'b0;
      spi_rx = 8'($urandom);
      if (done != 2'b00) begin
        fin = 1'b1;
        o.seen = 1'b1;
        o.done = done;
        o.gnt_d = gnt;
        o.err = err;
        o.rdata = rdata;
        o.tx_d = spi_tx;
        o.lat = cyc - s - 1;
        tip = 1'b0;
        if (!keep) req = 2'b00;
      end else if (s >= 0) begin
        wdata = 16'($urandom);
        k = cyc - s;
        if (v.mode != M_TMO && k == v.tip_dly) tip = 1'b1;
        if (k == v.tip_dly + v.rcv_dly) begin
          case (v.mode)
            M_NORM:  begin receive_data = 1'b1; spi_rx = v.rx; end
            M_EARLY: tip = 1'b0;
            M_SIM:   begin receive_data = 1'b1; spi_rx = v.rx; tip = 1'b0; end
            default: ;
          endcase
        end
        if (k == v.tip_dly + v.rcv_dly + 1) tip = 1'b0;
      end
    end
    tip = 1'b0;
    receive_data = 1'b0;
    chk("done_seen", 32'(o.seen), 32'd1);
    if (!keep) begin
      @(negedge PCLK);
      o.busy_after = busy;
      o.gnt_after = gnt;
    end
  endtask

  task automatic check_obs(input string tag, input vec_t v, input bit keep, input obs_t o);
    chk({tag, ".n_send"}, o.n_send, 1);
    chk({tag, ".gnt_launch"}, o.gnt_l, v.e_gnt);
    chk({tag, ".spi_tx"}, o.tx, v.e_tx);
    chk({tag, ".spi_tx_hold"}, o.tx_d, v.e_tx);
    chk({tag, ".done"}, o.done, v.e_gnt);
    chk({tag, ".gnt_at_done"}, o.gnt_d, v.e_gnt);
    chk({tag, ".err"}, o.err, v.e_err);
    chk({tag, ".rdata"}, o.rdata, v.e_rd);
    chk({tag, ".stray"}, o.stray, 0);
    if (v.mode == M_TMO) chk({tag, ".wd_latency"}, o.lat, TMO);
    if (!keep) begin
      chk({tag, ".busy_after"}, o.busy_after, 0);
      chk({tag, ".gnt_after"}, o.gnt_after, 0);
    end
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    obs_t o;
    int lw, w, c, md, dcnt;
    logic [7:0] exp_rd;
    bit keep;

    tbl[0] = '{2'b01, 8'hA5, 8'h00, 8'h3C, M_NORM,  3, 20, 2'b01, 8'hA5, 8'h3C, 1'b0};
    tbl[1] = '{2'b11, 8'h11, 8'h22, 8'h5A, M_NORM,  2,  5, 2'b10, 8'h22, 8'h5A, 1'b0};
    tbl[2] = '{2'b11, 8'h33, 8'h44, 8'h66, M_NORM,  1,  4, 2'b01, 8'h33, 8'h66, 1'b0};
    tbl[3] = '{2'b10, 8'h77, 8'h88, 8'h99, M_EARLY, 2,  6, 2'b10, 8'h88, 8'h66, 1'b1};
    tbl[4] = '{2'b10, 8'h12, 8'h34, 8'h55, M_TMO,   0,  0, 2'b10, 8'h34, 8'h66, 1'b1};
    tbl[5] = '{2'b01, 8'h9A, 8'hBC, 8'hC3, M_SIM,   3,  3, 2'b01, 8'h9A, 8'hC3, 1'b0};
    tbl[6] = '{2'b11, 8'hDE, 8'hF0, 8'h0F, M_NORM,  0,  2, 2'b10, 8'hF0, 8'h0F, 1'b0};

    #1 PRESETn = 1'b0;
    #1;
    chk("rst.gnt", gnt, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.busy", busy, 0);
    chk("rst.send_data", send_data, 0);
    chk("rst.spi_tx", spi_tx, 0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_xfer(tbl[i], 1'b0, o);
      check_obs($sformatf("vec%0d", i), tbl[i], 1'b0, o);
    end

    // Reset during WAIT_RCV: everything clears immediately and no done escapes.
    req = 2'b01;
    wdata = {8'h00, 8'h5E};
    for (int i = 0; i < 10 && !send_data; i++) @(negedge PCLK);
    chk("mr.launch", send_data, 1);
    tip = 1'b1;
    repeat (4) @(negedge PCLK);
    chk("mr.busy_pre", busy, 1);
    PRESETn = 1'b0;
    #1;
    chk("mr.gnt", gnt, 0);
    chk("mr.busy", busy, 0);
    chk("mr.done", done, 0);
    chk("mr.err", err, 0);
    chk("mr.send_data", send_data, 0);
    chk("mr.rdata", rdata, 0);
    chk("mr.spi_tx", spi_tx, 0);
    tip = 1'b0;
    req = 2'b00;
    dcnt = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (done != 2'b00) dcnt++;
    end
    chk("mr.no_done", dcnt, 0);
    PRESETn = 1'b1;
    v = '{2'b11, 8'h6B, 8'h7C, 8'h21, M_NORM, 2, 3, 2'b01, 8'h6B, 8'h21, 1'b0};
    run_xfer(v, 1'b0, o);
    check_obs("post_rst", v, 1'b0, o);
    lw = 0;
    exp_rd = 8'h21;

`ifdef SPI_ARB_LOCK_EN
    begin : lock_seq
      logic [7:0] bytes [3];
      logic [7:0] txs [3];
      int nsend, ndone, k, gap, gbad;
      bytes = '{8'h11, 8'h22, 8'h33};
      txs = '{8'h00, 8'h00, 8'h00};
      nsend = 0; ndone = 0; k = 0; gap = 0; gbad = 0;
      lock = 2'b01;
      req = 2'b11;
      wdata = {8'h99, 8'h11};
      for (int cy = 0; cy < 200 && ndone < 3; cy++) begin
        @(negedge PCLK);
        receive_data = 1'b0;
        if (nsend > 0 && !busy) gap++;
        if (nsend > 0 && gnt != 2'b01) gbad++;
        if (send_data) begin
          if (nsend < 3) txs[nsend] = spi_tx;
          nsend++;
          k = 0;
          if (nsend == 3) lock = 2'b00;
        end else begin
          k++;
        end
        if (done != 2'b00) begin
          ndone++;
          tip = 1'b0;
          if (ndone < 3) wdata[7:0] = bytes[ndone];
          else req = 2'b10;
        end else if (nsend > 0 && k == 1) begin
          tip = 1'b1;
        end else if (nsend > 0 && k == 3) begin
          receive_data = 1'b1;
          spi_rx = 8'hE0;
        end
      end
      tip = 1'b0;
      receive_data = 1'b0;
      chk("lock.n_send", nsend, 3);
      chk("lock.n_done", ndone, 3);
      chk("lock.idle_gap", gap, 0);
      chk("lock.gnt_held", gbad, 0);
      chk("lock.tx0", txs[0], 8'h11);
      chk("lock.tx1", txs[1], 8'h22);
      chk("lock.tx2", txs[2], 8'h33);
      v = '{2'b10, 8'h00, 8'h44, 8'h45, M_NORM, 2, 3, 2'b10, 8'h44, 8'h45, 1'b0};
      run_xfer(v, 1'b0, o);
      check_obs("after_lock", v, 1'b0, o);
      lw = 1;
      exp_rd = 8'h45;
    end
`endif

    // Randomized transfers against a round-robin reference model.
    for (int n = 0; n < 40; n++) begin
      v.req = 2'($urandom_range(1, 3));
      c = $urandom_range(0, 9);
      md = (c == 0) ? M_TMO : (c < 3) ? M_EARLY : (c < 5) ? M_SIM : M_NORM;
      v.mode = md;
      v.tip_dly = $urandom_range(1, 5);
      v.rcv_dly = $urandom_range(1, 8);
      v.wd0 = 8'($urandom);
      v.wd1 = 8'($urandom);
      v.rx = 8'($urandom);
      w = -1;
      for (int j = 1; j <= 2; j++) begin
        c = (lw + j) % 2;
        if (w < 0 && ((v.req >> c) & 2'b01) != 2'b00) w = c;
      end
      v.e_gnt = 2'b01 << w;
      v.e_tx = (w == 1) ? v.wd1 : v.wd0;
      v.e_err = (md == M_EARLY || md == M_TMO);
      if (!v.e_err) exp_rd = v.rx;
      v.e_rd = exp_rd;
      lw = w;
      keep = 1'($urandom_range(0, 1));
      run_xfer(v, keep, o);
      check_obs($sformatf("rnd%0d", n), v, keep, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
